// File: rtl/y_signature_compactor.sv
// y_signature_compactor: samples a wide response bus on each valid clock,
// folds it to 32 bits and compacts a fixed-length run into a MISR signature.
// Optional macro Y_SIG_COMPARE_EN adds exp_sig / mismatch comparison.
module y_signature_compactor #(
    parameter int          Y_WIDTH = 1490,
    parameter int          SAMPLES = 20,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] SEED    = 32'hFFFFFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               y_valid,
    input  logic [Y_WIDTH-1:0] y,
    output logic               busy,
    output logic               done,
    output logic [31:0]        signature,
    output logic [15:0]        sample_count
`ifdef Y_SIG_COMPARE_EN
    ,
    input  logic [31:0]        exp_sig,
    output logic               mismatch
`endif
);

    localparam int          NWORDS    = (Y_WIDTH + 31) / 32;
    localparam int          PAD_W     = NWORDS * 32;
    localparam logic [15:0] LAST_IDX  = 16'(SAMPLES - 1);
    localparam logic [15:0] SAMPLES16 = 16'(SAMPLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sig_q, sig_d;
    logic [31:0] fold_q, fold_d;
    logic        fold_v_q, fold_v_d;
    logic [15:0] count_q, count_d;
    logic        accept;
    logic        restart;
    logic [PAD_W-1:0] y_pad;
    logic [31:0] words [NWORDS];
    logic [31:0] fold_w;

    // Zero-extend y so it splits cleanly into 32-bit words
    always_comb begin
        y_pad              = '0;
        y_pad[Y_WIDTH-1:0] = y;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_words
            assign words[gi] = y_pad[32*gi +: 32];
        end
    endgenerate

    // XOR-fold all words; stage 1 register isolates this tree from the MISR
    always_comb begin
        fold_w = '0;
        for (int k = 0; k < NWORDS; k++) begin
            fold_w = fold_w ^ words[k];
        end
    end

    assign accept  = (state_q == S_RUN) && y_valid && (count_q < SAMPLES16);
    assign restart = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Next-state, MISR stage and sample counter
    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        fold_d   = fold_q;
        fold_v_d = 1'b0;
        count_d  = count_q;

        if (fold_v_q) begin
            sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold_q;
        end

        if (accept) begin
            fold_d   = fold_w;
            fold_v_d = 1'b1;
            count_d  = count_q + 16'd1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (restart) begin
                    state_d = S_RUN;
                    sig_d   = SEED;
                    count_d = '0;
                end
            end
            S_RUN: begin
                if (accept && (count_q == LAST_IDX)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // last fold lands in sig_d this cycle
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, async reset aborts any run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sig_q    <= SEED;
            fold_q   <= '0;
            fold_v_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            fold_q   <= fold_d;
            fold_v_q <= fold_v_d;
            count_q  <= count_d;
        end
    end

    assign busy         = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done         = (state_q == S_DONE);
    assign signature    = sig_q;
    assign sample_count = count_q;

`ifdef Y_SIG_COMPARE_EN
    logic mismatch_q, mismatch_d;

    // Compare the final signature on the edge done rises; hold until restart
    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == S_FLUSH) begin
            mismatch_d = (sig_d != exp_sig);
        end else if (restart) begin
            mismatch_d = 1'b0;
        end
    end

    // Mismatch flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_y_signature_compactor.sv
// Testbench for y_signature_compactor: one SAMPLES=1 instance for known
// vectors and one SAMPLES=20 instance for randomized runs vs a reference model.
module tb_y_signature_compactor;

    localparam int          YW   = 1490;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start1, yv1;
    logic [YW-1:0] y1;
    logic          busy1, done1;
    logic [31:0]   sig1;
    logic [15:0]   cnt1;

    logic          start20, yv20;
    logic [YW-1:0] y20;
    logic          busy20, done20;
    logic [31:0]   sig20;
    logic [15:0]   cnt20;

`ifdef Y_SIG_COMPARE_EN
    logic [31:0] exp1;
    logic        mism1, mism20;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [YW-1:0] ys [20];

    y_signature_compactor #(.Y_WIDTH(YW), .SAMPLES(1), .POLY(POLY), .SEED(SEED)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y_valid(yv1), .y(y1),
        .busy(busy1), .done(done1), .signature(sig1), .sample_count(cnt1)
`ifdef Y_SIG_COMPARE_EN
        , .exp_sig(exp1), .mismatch(mism1)
`endif
    );

    y_signature_compactor #(.Y_WIDTH(YW), .SAMPLES(20), .POLY(POLY), .SEED(SEED)) dut20 (
        .clk(clk), .rst(rst), .start(start20), .y_valid(yv20), .y(y20),
        .busy(busy20), .done(done20), .signature(sig20), .sample_count(cnt20)
`ifdef Y_SIG_COMPARE_EN
        , .exp_sig(32'h0), .mismatch(mism20)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] fold_ref(input logic [YW-1:0] v);
        logic [31:0] f = '0;
        for (int i = 0; i < YW; i++) begin
            if (v[i]) f[i % 32] = ~f[i % 32];
        end
        return f;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
        logic [31:0] n = s << 1;
        if (s[31]) n = n ^ POLY;
        return n ^ f;
    endfunction

    function automatic logic [31:0] misr_ref(input int n);
        logic [31:0] s = SEED;
        for (int k = 0; k < n; k++) s = misr_step(s, fold_ref(ys[k]));
        return s;
    endfunction

    function automatic logic [YW-1:0] rand_y();
        logic [YW-1:0] v;
        logic [31:0]   r = '0;
        for (int i = 0; i < YW; i++) begin
            if (i % 32 == 0) r = $urandom;
            v[i] = r[i % 32];
        end
        return v;
    endfunction

    task automatic new_stim;
        for (int k = 0; k < 20; k++) ys[k] = rand_y();
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive a 1010... run on dut20 until done or the cycle budget runs out
    task automatic run20(input bit do_start, input int start_at, output int cycles, output bit timeout);
        int idx = 0;
        if (do_start) begin
            start20 = 1'b1;
            tick();
            start20 = 1'b0;
        end
        cycles = 0;
        while (!done20 && cycles < 300) begin
            yv20    = (cycles % 2 == 0) && (idx < 20);
            y20     = yv20 ? ys[idx] : rand_y();
            start20 = (cycles == start_at);
            if (yv20) idx++;
            tick();
            cycles++;
        end
        yv20    = 1'b0;
        start20 = 1'b0;
        timeout = !done20;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        n_cmp++; if (sig1 !== SEED || sig20 !== SEED) begin n_err++; $display("FAIL reset_sig: got %h/%h expected %h", sig1, sig20, SEED); end
        n_cmp++; if (cnt1 !== 16'd0 || cnt20 !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d/%0d expected 0", cnt1, cnt20); end
        n_cmp++; if ({busy1, done1, busy20, done20} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", {busy1, done1, busy20, done20}); end
        $display("test_reset: sig=%h count=%0d", sig20, cnt20);
    endtask

    task automatic test_known;
        logic [YW-1:0] v;
        logic [31:0]   exp_s;
        for (int t = 0; t < 4; t++) begin
            v = '0;
            case (t)
                0: exp_s = 32'hFB3EE249;
                1: begin v[0] = 1'b1; exp_s = 32'hFB3EE248; end
                2: begin v[0] = 1'b1; v[32] = 1'b1; exp_s = 32'hFB3EE249; end
                default: begin v[YW-1] = 1'b1; exp_s = 32'hFB3CE249; end
            endcase
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            n_cmp++; if (busy1 !== 1'b1 || done1 !== 1'b0 || sig1 !== SEED) begin n_err++; $display("FAIL known_start[%0d]: busy=%b done=%b sig=%h expected 1 0 %h", t, busy1, done1, sig1, SEED); end
            yv1 = 1'b1; y1 = v;
            tick();
            yv1 = 1'b0; y1 = rand_y();
            n_cmp++; if (done1 !== 1'b0 || busy1 !== 1'b1 || cnt1 !== 16'd1) begin n_err++; $display("FAIL known_flush[%0d]: done=%b busy=%b count=%0d expected 0 1 1", t, done1, busy1, cnt1); end
            tick();
            n_cmp++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin n_err++; $display("FAIL known_done[%0d]: done=%b busy=%b expected 1 0", t, done1, busy1); end
            n_cmp++; if (sig1 !== exp_s || sig1 !== misr_step(SEED, fold_ref(v))) begin n_err++; $display("FAIL known_sig[%0d]: got %h expected %h", t, sig1, exp_s); end
            // signature and count frozen in DONE even with valid input
            yv1 = 1'b1;
            tick(); tick();
            yv1 = 1'b0;
            n_cmp++; if (sig1 !== exp_s || cnt1 !== 16'd1 || done1 !== 1'b1) begin n_err++; $display("FAIL known_frozen[%0d]: sig=%h count=%0d done=%b expected %h 1 1", t, sig1, cnt1, done1, exp_s); end
            $display("test_known[%0d]: sig=%h count=%0d", t, sig1, cnt1);
        end
    endtask

    task automatic test_toggle;
        int          idx = 0;
        int          cyc = 0;
        logic [31:0] m_sig = SEED;
        logic [31:0] m_fold = '0;
        bit          m_pend = 1'b0;
        new_stim();
        start20 = 1'b1;
        tick();
        start20 = 1'b0;
        n_cmp++; if (busy20 !== 1'b1 || cnt20 !== 16'd0 || sig20 !== SEED) begin n_err++; $display("FAIL toggle_start: busy=%b count=%0d sig=%h", busy20, cnt20, sig20); end
        while (!done20 && cyc < 200) begin
            yv20 = (cyc % 2 == 0) && (idx < 20);
            y20  = yv20 ? ys[idx] : rand_y();
            if (m_pend) m_sig = misr_step(m_sig, m_fold);
            m_pend = yv20;
            if (yv20) begin m_fold = fold_ref(ys[idx]); idx++; end
            tick();
            cyc++;
            n_cmp++; if (sig20 !== m_sig || cnt20 !== 16'(idx)) begin n_err++; $display("FAIL toggle_step[%0d]: sig=%h count=%0d expected %h %0d", cyc, sig20, cnt20, m_sig, idx); end
            n_cmp++; if (busy20 === 1'b1 && done20 === 1'b1) begin n_err++; $display("FAIL toggle_busy_done[%0d]: busy=1 done=1 expected exclusive", cyc); end
        end
        yv20 = 1'b0;
        n_cmp++; if (cyc != 40 || done20 !== 1'b1) begin n_err++; $display("FAIL toggle_latency: cycles=%0d done=%b expected 40 1", cyc, done20); end
        n_cmp++; if (sig20 !== misr_ref(20) || cnt20 !== 16'd20 || busy20 !== 1'b0) begin n_err++; $display("FAIL toggle_final: sig=%h count=%0d busy=%b expected %h 20 0", sig20, cnt20, busy20, misr_ref(20)); end
        $display("test_toggle: sig=%h count=%0d cycles=%0d", sig20, cnt20, cyc);
    endtask

    task automatic test_abort;
        int cyc;
        bit to;
        new_stim();
        start20 = 1'b1;
        tick();
        start20 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            yv20 = 1'b1; y20 = ys[k];
            tick();
        end
        yv20 = 1'b0;
        n_cmp++; if (cnt20 !== 16'd7 || busy20 !== 1'b1) begin n_err++; $display("FAIL abort_pre: count=%0d busy=%b expected 7 1", cnt20, busy20); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (sig20 !== SEED || cnt20 !== 16'd0 || busy20 !== 1'b0 || done20 !== 1'b0) begin n_err++; $display("FAIL abort_reset: sig=%h count=%0d busy=%b done=%b expected %h 0 0 0", sig20, cnt20, busy20, done20, SEED); end
        tick();
        rst = 1'b0;
        tick();
        run20(1'b1, -1, cyc, to);
        n_cmp++; if (to || sig20 !== misr_ref(20) || cnt20 !== 16'd20) begin n_err++; $display("FAIL abort_fresh: timeout=%0d sig=%h count=%0d expected 0 %h 20", to, sig20, cnt20, misr_ref(20)); end
        $display("test_abort: sig=%h count=%0d", sig20, cnt20);
    endtask

    task automatic test_start_ignored;
        int          cyc;
        bit          to;
        logic [31:0] first;
        new_stim();
        run20(1'b1, 9, cyc, to);
        first = sig20;
        n_cmp++; if (to || cyc != 40 || cnt20 !== 16'd20) begin n_err++; $display("FAIL start_in_run: timeout=%0d cycles=%0d count=%0d expected 0 40 20", to, cyc, cnt20); end
        n_cmp++; if (sig20 !== misr_ref(20)) begin n_err++; $display("FAIL start_in_run_sig: got %h expected %h", sig20, misr_ref(20)); end
`ifdef Y_SIG_COMPARE_EN
        n_cmp++; if (mism20 !== (misr_ref(20) != 32'h0)) begin n_err++; $display("FAIL mismatch20: got %b expected %b", mism20, misr_ref(20) != 32'h0); end
`endif
        start20 = 1'b1;
        tick();
        start20 = 1'b0;
        n_cmp++; if (done20 !== 1'b0 || busy20 !== 1'b1 || sig20 !== SEED || cnt20 !== 16'd0) begin n_err++; $display("FAIL start_in_done: done=%b busy=%b sig=%h count=%0d expected 0 1 %h 0", done20, busy20, sig20, cnt20, SEED); end
        run20(1'b0, -1, cyc, to);
        n_cmp++; if (to || sig20 !== misr_ref(20)) begin n_err++; $display("FAIL rerun_sig: timeout=%0d got %h expected %h", to, sig20, misr_ref(20)); end
        $display("test_start_ignored: first=%h second=%h", first, sig20);
    endtask

`ifdef Y_SIG_COMPARE_EN
    task automatic test_compare;
        for (int t = 0; t < 2; t++) begin
            exp1   = (t == 0) ? 32'hFB3EE249 : 32'h0;
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            n_cmp++; if (mism1 !== 1'b0) begin n_err++; $display("FAIL compare_cleared[%0d]: got %b expected 0", t, mism1); end
            yv1 = 1'b1; y1 = '0;
            tick();
            yv1 = 1'b0;
            n_cmp++; if (mism1 !== 1'b0) begin n_err++; $display("FAIL compare_flush[%0d]: got %b expected 0", t, mism1); end
            tick();
            n_cmp++; if (mism1 !== (t == 1) || done1 !== 1'b1) begin n_err++; $display("FAIL compare_done[%0d]: mismatch=%b done=%b expected %b 1", t, mism1, done1, t == 1); end
            $display("test_compare[%0d]: exp=%h mismatch=%b", t, exp1, mism1);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start1 = 1'b0; yv1 = 1'b0; y1 = '0;
        start20 = 1'b0; yv20 = 1'b0; y20 = '0;
`ifdef Y_SIG_COMPARE_EN
        exp1 = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_known();
        test_toggle();
        test_abort();
        test_start_ignored();
`ifdef Y_SIG_COMPARE_EN
        test_compare();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
